// File: rtl/clip_player_pkg.sv
// -----------------------------------------------------------------------------
// clip_player_pkg
//   Shared types and constants for the clip player.
//   - state_t     : playback FSM state (IDLE / PLAY)
//   - *_START/END : default ROM bounds of the whack-a-mole sound clips
//   - CLIP_*      : clip index names (index 0 has the highest priority)
// -----------------------------------------------------------------------------
package clip_player_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  // Default segment bounds inside the sound ROM (end addresses are inclusive).
  localparam logic [17:0] WIN_START    = 18'd0;
  localparam logic [17:0] WIN_END      = 18'd16395;
  localparam logic [17:0] MOO_START    = 18'd16396;
  localparam logic [17:0] MOO_END      = 18'd66982;
  localparam logic [17:0] DETECT_START = 18'd66983;
  localparam logic [17:0] DETECT_END   = 18'd83254;
  localparam logic [17:0] CHEER_START  = 18'd83255;
  localparam logic [17:0] CHEER_END    = 18'd137138;

  localparam int CLIP_WIN    = 0;
  localparam int CLIP_MOO    = 1;
  localparam int CLIP_DETECT = 2;
  localparam int CLIP_CHEER  = 3;

endpackage

// File: rtl/clip_rate_divider.sv
// -----------------------------------------------------------------------------
// clip_rate_divider
//   Sample-rate divider. Counts 0..DIV-1 and raises tick while the count sits
//   at DIV-1 and the codec allows output. Without allow the count parks at
//   DIV-1 until the codec has room again.
//   Ports:
//     CLOCK_50 : system clock
//     resetn   : asynchronous active-low reset
//     clear    : force the count back to zero on the next edge
//     allow    : codec output-allowed handshake
//     tick     : combinational sample strobe
// -----------------------------------------------------------------------------
module clip_rate_divider #(
  parameter int DIV = 1200
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic clear,
  input  logic allow,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] div_cnt_reg;
  logic             at_last;

  assign at_last = (div_cnt_reg == LAST);
  assign tick    = at_last && allow;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      div_cnt_reg <= '0;
    end else if (clear) begin
      div_cnt_reg <= '0;
    end else if (at_last) begin
      // Stall: hold at DIV-1 until the codec accepts the sample.
      if (allow) div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clip_player.sv
// -----------------------------------------------------------------------------
// clip_player
//   Multi-clip audio sample sequencer. Plays one ROM segment out of a table of
//   NUM_CLIPS segments at one sample per DIV clocks, with per-clip loop mode,
//   priority preemption (lower index wins), stop, and codec back-pressure.
//   Ports:
//     CLOCK_50          : system clock
//     resetn            : asynchronous active-low reset
//     trigger           : per-clip start request
//     loop_en           : per-clip loop mode, sampled at the clip end
//     stop              : abort playback
//     audio_out_allowed : codec FIFO has room
//     rom_q             : ROM data (one-cycle read latency)
//     rom_addr          : ROM address
//     sample_out        : left-justified sample for the left channel
//     sample_valid      : one-cycle pulse per delivered sample
//     busy              : high while playing
//     active_clip       : index of the playing clip
//     done              : one-cycle pulse when a one-shot clip completes
// -----------------------------------------------------------------------------
module clip_player
  import clip_player_pkg::*;
#(
  parameter int NUM_CLIPS = 4,
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 6,
  parameter int DIV       = 1200,
  parameter logic [NUM_CLIPS*ADDR_W-1:0] CLIP_START =
    {CHEER_START, DETECT_START, MOO_START, WIN_START},
  parameter logic [NUM_CLIPS*ADDR_W-1:0] CLIP_END =
    {CHEER_END, DETECT_END, MOO_END, WIN_END}
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic [NUM_CLIPS-1:0] trigger,
  input  logic [NUM_CLIPS-1:0] loop_en,
  input  logic                 stop,
  input  logic                 audio_out_allowed,
  input  logic [DATA_W-1:0]    rom_q,
  output logic [ADDR_W-1:0]    rom_addr,
  output logic [31:0]          sample_out,
  output logic                 sample_valid,
  output logic                 busy,
  output logic [2:0]           active_clip,
  output logic                 done
);

  state_t              state_reg;
  logic [ADDR_W-1:0]   rom_addr_reg;
  logic [31:0]         sample_out_reg;
  logic                sample_valid_reg;
  logic                busy_reg;
  logic [2:0]          active_clip_reg;
  logic                done_reg;

  logic [ADDR_W-1:0]   clip_start_arr [NUM_CLIPS];
  logic [ADDR_W-1:0]   clip_end_arr   [NUM_CLIPS];

  logic                trig_any;
  logic [2:0]          trig_idx;
  logic [ADDR_W-1:0]   trig_start;
  logic [ADDR_W-1:0]   cur_start;
  logic [ADDR_W-1:0]   cur_end;
  logic                cur_loop;
  logic                accept;
  logic                tick;
  logic                div_clear;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLIPS; gi++) begin : g_clip_table
      assign clip_start_arr[gi] = CLIP_START[gi*ADDR_W +: ADDR_W];
      assign clip_end_arr[gi]   = CLIP_END[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Priority encode the trigger (scan downwards so the lowest index wins) and
  // mux out the bounds of the clip currently playing.
  always_comb begin
    trig_any   = 1'b0;
    trig_idx   = '0;
    trig_start = '0;
    cur_start  = '0;
    cur_end    = '0;
    cur_loop   = 1'b0;
    for (int i = NUM_CLIPS - 1; i >= 0; i--) begin
      if (trigger[i]) begin
        trig_any   = 1'b1;
        trig_idx   = 3'(i);
        trig_start = clip_start_arr[i];
      end
    end
    for (int i = 0; i < NUM_CLIPS; i++) begin
      if (active_clip_reg == 3'(i)) begin
        cur_start = clip_start_arr[i];
        cur_end   = clip_end_arr[i];
        cur_loop  = loop_en[i];
      end
    end
  end

  // Lower or equal index preempts/restarts; higher index is ignored in PLAY.
  assign accept    = trig_any && ((state_reg == IDLE) || (trig_idx <= active_clip_reg));
  // Divider runs only while playing and restarts on every (re)load or stop.
  assign div_clear = (state_reg != PLAY) || accept || stop;

  clip_rate_divider #(
    .DIV (DIV)
  ) u_divider (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .clear    (div_clear),
    .allow    (audio_out_allowed),
    .tick     (tick)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_reg        <= IDLE;
      rom_addr_reg     <= '0;
      sample_out_reg   <= '0;
      sample_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
      active_clip_reg  <= '0;
      done_reg         <= 1'b0;
    end else begin
      sample_valid_reg <= 1'b0;
      done_reg         <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (trig_any) begin
            state_reg       <= PLAY;
            busy_reg        <= 1'b1;
            rom_addr_reg    <= trig_start;
            active_clip_reg <= trig_idx;
          end
        end
        PLAY: begin
          if (stop) begin
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
            sample_out_reg <= '0;
          end else begin
            if (tick) begin
              sample_out_reg   <= 32'(rom_q) << (32 - DATA_W);
              sample_valid_reg <= 1'b1;
            end
            // An accepted trigger reloads the address even on a tick edge,
            // which also suppresses the end-of-clip handling.
            if (accept) begin
              rom_addr_reg    <= trig_start;
              active_clip_reg <= trig_idx;
            end else if (tick) begin
              if (rom_addr_reg != cur_end) begin
                rom_addr_reg <= rom_addr_reg + ADDR_W'(1);
              end else if (cur_loop) begin
                rom_addr_reg <= cur_start;
              end else begin
                done_reg  <= 1'b1;
                busy_reg  <= 1'b0;
                state_reg <= IDLE;
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rom_addr     = rom_addr_reg;
  assign sample_out   = sample_out_reg;
  assign sample_valid = sample_valid_reg;
  assign busy         = busy_reg;
  assign active_clip  = active_clip_reg;
  assign done         = done_reg;

endmodule

// File: doc/clip_player.md
Name: clip_player

Overview:
- Parametrised multi-clip audio sample sequencer for the whack-a-mole datapath; it replaces the single hard-wired play_sound address counter.
- Holds a table of NUM_CLIPS ROM segments (start/end address) and plays one segment at a fixed sample-rate divider.
- Supports per-clip one-shot or loop mode, priority preemption, explicit stop, and stall on the audio codec's output-allowed handshake.
- Drives the sound ROM address and feeds the left channel of Audio_Controller.

Parameters:
- NUM_CLIPS, 4, number of clip segments (1..8).
- ADDR_W, 18, ROM address width.
- DATA_W, 6, ROM sample width (must be 1..32).
- DIV, 1200, CLOCK_50 cycles per sample tick (must be >= 2).
- CLIP_START, {18'd83255,18'd66983,18'd16396,18'd0}, packed start addresses; clip i at [i*ADDR_W +: ADDR_W].
- CLIP_END, {18'd137138,18'd83254,18'd66982,18'd16395}, packed end addresses (inclusive); same packing; CLIP_END[i] >= CLIP_START[i].

Ports:
- CLOCK_50 in 1: system clock.
- resetn in 1: asynchronous active-low reset.
- trigger in NUM_CLIPS: per-clip start request, sampled each cycle.
- loop_en in NUM_CLIPS: per-clip loop mode, sampled when that clip reaches its end.
- stop in 1: abort playback.
- audio_out_allowed in 1: codec FIFO has room.
- rom_q in DATA_W: ROM data, one-cycle synchronous read latency.
- rom_addr out ADDR_W: ROM address.
- sample_out out 32: {rom_q, zeros}, left-justified.
- sample_valid out 1: one-cycle pulse per delivered sample.
- busy out 1: high in PLAY.
- active_clip out 3: index of the playing clip.
- done out 1: one-cycle pulse when a one-shot clip completes.

Behaviour:
- Reset (async, resetn=0): state IDLE; rom_addr=0, sample_out=0, sample_valid=0, busy=0, active_clip=0, done=0, div_cnt=0. Reset mid-play abandons the clip with no done pulse.
- States:
  - IDLE: waiting for a trigger.
  - PLAY: stepping through the active segment.
- Arbitration: the lowest set index of trigger wins (index 0 = highest priority).
- IDLE -> PLAY on any trigger bit. Same edge: active_clip=k, rom_addr=CLIP_START[k], div_cnt=0, busy=1.
- PLAY, trigger on index j:
  - j < active_clip (preempt) or j == active_clip (restart): same load as IDLE -> PLAY.
  - j > active_clip: ignored.
- Tick: div_cnt == DIV-1 and audio_out_allowed=1.
  - sample_out <= {rom_q, (32-DATA_W)'b0}, sample_valid=1 for that cycle, div_cnt <= 0.
  - If rom_addr != CLIP_END[k]: rom_addr+1.
  - Else if loop_en[k]: rom_addr <= CLIP_START[k].
  - Else: done=1, go to IDLE, busy=0. rom_addr and active_clip hold their values.
- Stall: div_cnt == DIV-1 and audio_out_allowed=0 → div_cnt, rom_addr and sample_out hold; no sample_valid.
- Latency: first sample_valid occurs DIV cycles after the trigger edge (DIV >= 2 guarantees rom_q is valid).
- stop=1 in PLAY → IDLE next edge; sample_out <= 0, busy=0, no done. stop outranks trigger and tick in the same cycle.
- Trigger coincident with a tick:
  - Accepted preempt/restart wins; the tick sample is still emitted.
  - The address is reloaded, not advanced.
  - No done pulse even if that tick was the end of the old clip.
- Single-sample clip (start == end): one sample_valid per tick. With loop_en set, the same sample repeats.
- sample_out retains the last sample in IDLE after done (audio holds its level); it is cleared only by stop or reset.

Decomposition:
- Package clip_player_pkg:
  - state enum {IDLE, PLAY}.
  - localparams for the default clip bounds: WIN, MOO, DETECT, CHEER start/end.
  - Clip index names: CLIP_WIN=0, CLIP_MOO=1, CLIP_DETECT=2, CLIP_CHEER=3.
- Sub-module clip_rate_divider:
  - Holds div_cnt.
  - Inputs: clear, allow.
  - Output: tick.
  - Parameter: DIV.

Test Plan:
- DIV=4, clips {0..2, 10..11}. Pulse trigger[0] → rom_addr 0,1,2 with sample_valid every 4 cycles, first pulse 4 cycles after the trigger; done pulses on the third sample; busy falls.
- Same setup, loop_en[1]=1, trigger[1] → address sequence 10,11,10,11…; no done for 20 ticks.
- Play clip 1, then trigger[0] mid-clip → rom_addr jumps to 0 and active_clip=0. Then trigger[1] → ignored.
- Hold audio_out_allowed=0 for 10 cycles at a tick → no sample_valid and rom_addr frozen. Release → one sample, then normal 4-cycle spacing.
- stop asserted together with trigger[0] during play → IDLE, sample_out=0, no done.
- resetn low mid-play for 1 cycle, asynchronously → all outputs zero immediately; after release, stays IDLE until the next trigger.
